// File: rtl/rv32i_mem_pkg.sv
// ============================================================================
// Module  : rv32i_mem_pkg
// Purpose : Shared constants for the rv32i memory responder: region bases,
//           MMIO offsets, CTRL bit index, host FSM encoding, region decode.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32i_mem_pkg;

  // Region base addresses
  localparam logic [31:0] IMEM_BASE = 32'h0000_0000;
  localparam logic [31:0] DMEM_BASE = 32'h0001_0000;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  // MMIO register offsets
  localparam logic [31:0] MMIO_GPIO  = 32'h0000_0000;
  localparam logic [31:0] MMIO_CYCLE = 32'h0000_0004;
  localparam logic [31:0] MMIO_CTRL  = 32'h0000_0008;

  // CTRL register bit holding the run flag
  localparam int CTRL_RUN_BIT = 0;

  // Host FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // True when addr lands inside [base, base + 4*words); no wrap or aliasing.
  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] words);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ({2'b00, off[31:2]} < words);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_mem_bank.sv
// ============================================================================
// Module  : rv32i_mem_bank
// Purpose : Word RAM with two asynchronous read ports and one synchronous
//           write port. Contents are not reset.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rv32i_mem_bank #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] ra_addr,
  output logic [31:0]   ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [31:0]   rb_data,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);

  logic [31:0] r_mem [WORDS];

  assign ra_data = r_mem[ra_addr];
  assign rb_data = r_mem[rb_addr];

  // Single write port, committed at the rising edge
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/rv32i_mem_responder.sv
// ============================================================================
// Module  : rv32i_mem_responder
// Purpose : IMEM + DMEM + MMIO (GPIO, CYCLE, CTRL) behind the rv32i core
//           fetch/data ports, with a Wishbone-classic host loader port.
//           Optional macro RV32I_MEM_CYCLE_CNT_EN enables the CYCLE counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

import rv32i_mem_pkg::*;

module rv32i_mem_responder #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  input  logic        host_stb,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic [31:0] host_rdata,
  output logic        core_rst,
  output logic [7:0]  gpio_out
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [31:0] C_GPIO_ADDR  = MMIO_BASE + MMIO_GPIO;
  localparam logic [31:0] C_CYCLE_ADDR = MMIO_BASE + MMIO_CYCLE;
  localparam logic [31:0] C_CTRL_ADDR  = MMIO_BASE + MMIO_CTRL;

  logic [1:0]  r_state;
  logic [31:0] r_host_rdata;
  logic [7:0]  r_gpio;
  logic        r_run;
  logic [31:0] w_cycle;

  // Address decode, core side
  logic w_pc_imem, w_core_dmem, w_core_gpio, w_core_cycle, w_core_ctrl;
  assign w_pc_imem    = in_region(pc, IMEM_BASE, 32'(IMEM_WORDS));
  assign w_core_dmem  = in_region(mem_addr, DMEM_BASE, 32'(DMEM_WORDS));
  assign w_core_gpio  = (mem_addr[31:2] == C_GPIO_ADDR[31:2]);
  assign w_core_cycle = (mem_addr[31:2] == C_CYCLE_ADDR[31:2]);
  assign w_core_ctrl  = (mem_addr[31:2] == C_CTRL_ADDR[31:2]);

  // Address decode, host side
  logic w_host_imem, w_host_dmem, w_host_gpio, w_host_cycle, w_host_ctrl;
  assign w_host_imem  = in_region(host_addr, IMEM_BASE, 32'(IMEM_WORDS));
  assign w_host_dmem  = in_region(host_addr, DMEM_BASE, 32'(DMEM_WORDS));
  assign w_host_gpio  = (host_addr[31:2] == C_GPIO_ADDR[31:2]);
  assign w_host_cycle = (host_addr[31:2] == C_CYCLE_ADDR[31:2]);
  assign w_host_ctrl  = (host_addr[31:2] == C_CTRL_ADDR[31:2]);

  // Word indices inside each array
  logic [31:0] w_pc_off, w_core_doff, w_host_ioff, w_host_doff;
  assign w_pc_off    = pc - IMEM_BASE;
  assign w_core_doff = mem_addr - DMEM_BASE;
  assign w_host_ioff = host_addr - IMEM_BASE;
  assign w_host_doff = host_addr - DMEM_BASE;

  // Core write strobes (core can never write IMEM or CYCLE)
  logic w_core_dmem_we, w_core_gpio_we, w_core_ctrl_we;
  assign w_core_dmem_we = mem_we & w_core_dmem;
  assign w_core_gpio_we = mem_we & w_core_gpio;
  assign w_core_ctrl_we = mem_we & w_core_ctrl;

  // Host stalls whenever the core writes the same array/register this cycle
  logic w_collide, w_host_go;
  assign w_collide = (w_host_dmem & w_core_dmem_we) |
                     (w_host_gpio & w_core_gpio_we) |
                     (w_host_ctrl & w_core_ctrl_we);
  assign w_host_go = host_stb & ~w_collide &
                     ((r_state == ST_IDLE) | (r_state == ST_WAIT));

  logic w_host_wr;
  assign w_host_wr = w_host_go & host_we;

  logic [31:0] w_imem_fetch, w_imem_host, w_dmem_core, w_dmem_host;

  rv32i_mem_bank #(.WORDS(IMEM_WORDS)) u_imem (
    .clk     (clk),
    .ra_addr (w_pc_off[IAW+1:2]),
    .ra_data (w_imem_fetch),
    .rb_addr (w_host_ioff[IAW+1:2]),
    .rb_data (w_imem_host),
    .we      (w_host_wr & w_host_imem),
    .waddr   (w_host_ioff[IAW+1:2]),
    .wdata   (host_wdata)
  );

  rv32i_mem_bank #(.WORDS(DMEM_WORDS)) u_dmem (
    .clk     (clk),
    .ra_addr (w_core_doff[DAW+1:2]),
    .ra_data (w_dmem_core),
    .rb_addr (w_host_doff[DAW+1:2]),
    .rb_data (w_dmem_host),
    .we      (w_core_dmem_we | (w_host_wr & w_host_dmem)),
    .waddr   (w_core_dmem_we ? w_core_doff[DAW+1:2] : w_host_doff[DAW+1:2]),
    .wdata   (w_core_dmem_we ? mem_wdata : host_wdata)
  );

  assign instr = w_pc_imem ? w_imem_fetch : 32'h0;

  // Core load mux: DMEM or MMIO, everything else reads zero
  always_comb begin
    mem_rdata = 32'h0;
    if (w_core_dmem)       mem_rdata = w_dmem_core;
    else if (w_core_gpio)  mem_rdata = {24'h0, r_gpio};
    else if (w_core_cycle) mem_rdata = w_cycle;
    else if (w_core_ctrl)  mem_rdata = {31'h0, r_run};
  end

  // Host read mux
  logic [31:0] w_host_rd;
  always_comb begin
    w_host_rd = 32'h0;
    if (w_host_imem)       w_host_rd = w_imem_host;
    else if (w_host_dmem)  w_host_rd = w_dmem_host;
    else if (w_host_gpio)  w_host_rd = {24'h0, r_gpio};
    else if (w_host_cycle) w_host_rd = w_cycle;
    else if (w_host_ctrl)  w_host_rd = {31'h0, r_run};
  end

  // Host handshake FSM; a held stb during ACK is ignored until IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_host_rdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: if (host_stb) r_state <= w_collide ? ST_WAIT : ST_ACK;
        ST_WAIT: begin
          if (!host_stb)      r_state <= ST_IDLE;
          else if (w_collide) r_state <= ST_WAIT;
          else                r_state <= ST_ACK;
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_host_go) r_host_rdata <= host_we ? 32'h0 : w_host_rd;
    end
  end

  assign host_ack   = (r_state == ST_ACK);
  assign host_rdata = r_host_rdata;

  // GPIO and CTRL registers; core write wins (host is stalled on a clash)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gpio <= 8'h0;
      r_run  <= 1'b0;
    end else begin
      if (w_core_gpio_we)                r_gpio <= mem_wdata[7:0];
      else if (w_host_wr && w_host_gpio) r_gpio <= host_wdata[7:0];
      if (w_core_ctrl_we)                r_run  <= mem_wdata[CTRL_RUN_BIT];
      else if (w_host_wr && w_host_ctrl) r_run  <= host_wdata[CTRL_RUN_BIT];
    end
  end

`ifdef RV32I_MEM_CYCLE_CNT_EN
  logic [31:0] r_cycle;
  // Free-running cycle counter while the core is running; wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cycle <= 32'h0;
    else if (r_run) r_cycle <= r_cycle + 32'd1;
  end
  assign w_cycle = r_cycle;
`else
  assign w_cycle = 32'h0;
`endif

  assign gpio_out = r_gpio;
  assign core_rst = rst | ~r_run;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_mem_responder.sv
// ============================================================================
// Module  : tb_rv32i_mem_responder
// Purpose : Self-checking bench for rv32i_mem_responder: host vector table,
//           hand-written multi-cycle sequences and randomized core traffic
//           against a word-array reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv32i_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, instr, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic        host_stb, host_we, host_ack;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        core_rst;
  logic [7:0]  gpio_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32i_mem_responder #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .host_stb(host_stb), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .core_rst(core_rst), .gpio_out(gpio_out)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  // Reference model: DMEM window of 16 words and the GPIO register
  logic [31:0] dm [16];
  logic [7:0]  gpio_m;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One host transaction; lat = cycles from stb to ack (0 if never acked)
  task automatic host_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
    @(negedge clk);
    host_stb = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    lat = 0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (host_ack) begin lat = i; rd = host_rdata; break; end
    end
    @(negedge clk);
    host_stb = 1'b0; host_we = 1'b0;
  endtask

  task automatic core_store(input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    mem_we = 1'b1; mem_addr = addr; mem_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic core_load_check(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    mem_addr = addr; #1;
    check(nm, mem_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, c1, c2, a, d;
    logic [31:0] oor [5];
    int lat, k, idx;

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0050_0093, 32'h0};
    vecs[1]  = '{1'b1, 32'h0001_0010, 32'hA5A5_0001, 32'h0};
    vecs[2]  = '{1'b1, 32'h8000_0000, 32'h0000_01C3, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0};
    vecs[4]  = '{1'b1, 32'h8000_0004, 32'h0000_0055, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0050_0093};
    vecs[6]  = '{1'b0, 32'h0001_0010, 32'h0,         32'hA5A5_0001};
    vecs[7]  = '{1'b0, 32'h0001_0013, 32'h0,         32'hA5A5_0001};
    vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0,         32'h0000_00C3};
    vecs[9]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 32'h0001_0400, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 32'h8000_0004, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 32'h8000_000C, 32'h0,         32'h0};
    vecs[13] = '{1'b0, 32'h1234_5678, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 32'h8000_0008, 32'h0,         32'h0};
    vecs[15] = '{1'b0, 32'h0000_0003, 32'h0,         32'h0050_0093};

    oor[0] = 32'h0002_0000; oor[1] = 32'h0001_0400; oor[2] = 32'hFFFF_FFF0;
    oor[3] = 32'h8000_000C; oor[4] = 32'h0000_0010;

    rst = 1'b1; pc = '0; mem_addr = '0; mem_wdata = '0; mem_we = 1'b0;
    host_stb = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    #2;
    check("reset core_rst", {31'h0, core_rst}, 32'h1);
    check("reset host_ack", {31'h0, host_ack}, 32'h0);
    check("reset host_rdata", host_rdata, 32'h0);
    check("reset gpio_out", {24'h0, gpio_out}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("core_rst after reset", {31'h0, core_rst}, 32'h1);

    // Host vector table: every access acked one cycle after stb
    for (int i = 0; i < NV; i++) begin
      host_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
      if (!vecs[i].we) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
    end
    check("gpio_out after host write", {24'h0, gpio_out}, 32'hC3);

    // Load and release
    host_xfer(1'b1, 32'h8000_0008, 32'h1, rd, lat);
    check("ctrl write latency", 32'(lat), 32'd1);
    check("core_rst released", {31'h0, core_rst}, 32'h0);
    pc = 32'h0; #1;
    check("instr at pc 0", instr, 32'h0050_0093);
    pc = 32'h0000_0400; #1;
    check("instr out of range", instr, 32'h0);
    pc = 32'h0;

    // Core store then load; host reads the same word
    core_store(32'h0001_0008, 32'hDEAD_BEEF);
    check("core load after store", mem_rdata, 32'hDEAD_BEEF);
    host_xfer(1'b0, 32'h0001_0008, 32'h0, rd, lat);
    check("host read core data", rd, 32'hDEAD_BEEF);
    core_load_check("imem via data port", 32'h0000_0000, 32'h0);

    // Collision: core write wins this cycle, host retries next cycle
    @(negedge clk);
    host_stb = 1'b1; host_we = 1'b1; host_addr = 32'h0001_0004; host_wdata = 32'h1111_1111;
    mem_we = 1'b1; mem_addr = 32'h0001_0004; mem_wdata = 32'h2222_2222;
    @(posedge clk); #1;
    check("collision no early ack", {31'h0, host_ack}, 32'h0);
    check("collision core value", mem_rdata, 32'h2222_2222);
    @(negedge clk); mem_we = 1'b0;
    @(posedge clk); #1;
    check("collision ack after wait", {31'h0, host_ack}, 32'h1);
    @(negedge clk); host_stb = 1'b0; host_we = 1'b0;
    core_load_check("collision final value", 32'h0001_0004, 32'h1111_1111);

    // Counter (run=1 at this point)
`ifdef RV32I_MEM_CYCLE_CNT_EN
    @(negedge clk); mem_addr = 32'h8000_0004; #1; c1 = mem_rdata;
    repeat (10) @(negedge clk);
    #1; c2 = mem_rdata;
    check("cycle delta 10", c2 - c1, 32'd10);
    core_store(32'h8000_0008, 32'h0);
    check("core halts itself", {31'h0, core_rst}, 32'h1);
    mem_addr = 32'h8000_0004; #1; c1 = mem_rdata;
    repeat (5) @(negedge clk);
    #1;
    check("cycle holds when halted", mem_rdata, c1);
`else
    core_load_check("cycle reads zero", 32'h8000_0004, 32'h0);
    host_xfer(1'b0, 32'h8000_0004, 32'h0, rd, lat);
    check("host cycle reads zero", rd, 32'h0);
    core_store(32'h8000_0008, 32'h0);
    check("core halts itself", {31'h0, core_rst}, 32'h1);
`endif

    // Randomized core traffic against the model
    for (int i = 0; i < 16; i++) begin
      dm[i] = $urandom;
      host_xfer(1'b1, 32'h0001_0000 + 32'(i * 4), dm[i], rd, lat);
    end
    gpio_m = gpio_out;
    for (int it = 0; it < 80; it++) begin
      k = $urandom_range(0, 5);
      d = $urandom;
      idx = $urandom_range(0, 15);
      if (k <= 1) begin
        core_store(32'h0001_0000 + 32'(idx * 4), d);
        dm[idx] = d;
      end else if (k == 2) begin
        a = oor[$urandom_range(0, 4)];
        core_store(a, d);
        core_load_check("rand oor load", a, 32'h0);
      end else if (k == 3) begin
        core_store(32'h8000_0000, d);
        gpio_m = d[7:0];
        check("rand gpio", {24'h0, gpio_out}, {24'h0, gpio_m});
      end else if (k == 4) begin
        core_load_check($sformatf("rand load %0d", idx), 32'h0001_0000 + 32'(idx * 4), dm[idx]);
      end else begin
        host_xfer(1'b0, 32'h0001_0000 + 32'(idx * 4), 32'h0, rd, lat);
        check($sformatf("rand host read %0d", idx), rd, dm[idx]);
      end
    end
    for (int i = 0; i < 16; i++)
      core_load_check($sformatf("final dmem %0d", i), 32'h0001_0000 + 32'(i * 4), dm[i]);

    // Reset while in ACK: ack drops immediately, no second ack afterward
    core_store(32'h8000_0000, 32'h5A);
    host_xfer(1'b1, 32'h8000_0008, 32'h1, rd, lat);
    @(negedge clk);
    host_stb = 1'b1; host_we = 1'b0; host_addr = 32'h0001_0000;
    @(posedge clk); #1;
    check("ack before reset", {31'h0, host_ack}, 32'h1);
    rst = 1'b1; #1;
    check("reset mid-ack host_ack", {31'h0, host_ack}, 32'h0);
    check("reset mid-ack gpio", {24'h0, gpio_out}, 32'h0);
    check("reset mid-ack core_rst", {31'h0, core_rst}, 32'h1);
    @(negedge clk); host_stb = 1'b0; rst = 1'b0;
    host_xfer(1'b0, 32'h0001_0000, 32'h0, rd, lat);
    check("post-reset latency", 32'(lat), 32'd1);
    check("ram survives reset", rd, dm[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
